// File: rtl/i2s_pkg.sv
// i2s_pkg: shared types and helpers for the parametrised I2S / left-justified transmitter.
//   state_e      : frame sequencer states (IDLE, LEFT, RIGHT)
//   MODE_LJ/I2S  : values for the MODE parameter
//   frame_cycles : clk_12M cycles per stereo frame for a given slot width and divider
package i2s_pkg;
   typedef enum logic [1:0] {IDLE, LEFT, RIGHT} state_e;
   localparam int MODE_LJ  = 0;
   localparam int MODE_I2S = 1;
   function automatic int frame_cycles(input int slot_w, input int bclk_div);
      return 4 * slot_w * bclk_div;
   endfunction
endpackage

// File: rtl/i2s_bclk_gen.sv
// i2s_bclk_gen: bit-clock divider; bclk idles high and toggles every BCLK_DIV cycles while run is high.
//   clk_12M, rst : clock and synchronous active-high reset
//   run          : divider enable; low parks bclk at 1 and clears the count
//   bclk         : registered bit clock
//   fall_tick    : high in the cycle whose edge drives bclk 1->0
//   rise_tick    : high in the cycle whose edge drives bclk 0->1
module i2s_bclk_gen #(
   parameter int BCLK_DIV = 2
) (
   input  logic clk_12M,
   input  logic rst,
   input  logic run,
   output logic bclk,
   output logic fall_tick,
   output logic rise_tick
);
   localparam int DW = BCLK_DIV > 1 ? $clog2(BCLK_DIV) : 1;
   logic [DW-1:0] div_cnt;
   logic          wrap;
   assign wrap      = run && div_cnt == DW'(BCLK_DIV - 1);
   assign fall_tick = wrap && bclk;
   assign rise_tick = wrap && !bclk;
   always_ff @(posedge clk_12M) begin
      if (rst || !run) begin
         div_cnt <= '0;
         bclk    <= 1'b1;
      end else begin
         div_cnt <= wrap ? '0 : div_cnt + 1'b1;
         bclk    <= wrap ? !bclk : bclk;
      end
   end
endmodule

// File: rtl/i2s_tx_param.sv
// i2s_tx_param: stereo sample-pair to I2S / left-justified serialiser with underrun repeat and graceful stop.
//   clk_12M, rst            : clock and synchronous active-high reset
//   enable                  : run request; dropping it stops the link at the end of the current frame
//   s_valid/s_ready         : pair handshake into a one-deep holding register
//   s_left, s_right         : DATA_W-bit samples
//   bclk, lrclk, sdata      : serial link (lrclk 1 = left slot), MSB first
//   frame_start, underrun   : one-cycle pulses at the start of each frame
//   stats_clr, underrun_cnt : only with I2S_TX_STATS_EN defined; saturating underrun counter
module i2s_tx_param
   import i2s_pkg::*;
#(
   parameter int DATA_W   = 24,
   parameter int SLOT_W   = 32,
   parameter int BCLK_DIV = 2,
   parameter int MODE     = MODE_I2S
) (
   input  logic              clk_12M,
   input  logic              rst,
   input  logic              enable,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [DATA_W-1:0] s_left,
   input  logic [DATA_W-1:0] s_right,
   output logic              bclk,
   output logic              lrclk,
   output logic              sdata,
   output logic              frame_start,
`ifdef I2S_TX_STATS_EN
   input  logic              stats_clr,
   output logic [15:0]       underrun_cnt,
`endif
   output logic              underrun
);
   localparam int CW = SLOT_W > 1 ? $clog2(SLOT_W) : 1;
   state_e            state;
   logic [CW-1:0]     bit_cnt, nxt_cnt;
   logic              fresh, stop_pend, hold_full;
   logic [DATA_W-1:0] hold_l, hold_r, last_l, last_r, sh_l, sh_r, load_l, load_r, word;
   logic [SLOT_W-1:0] slot_vec;
   logic              run, fall_tick, rise_tick, bound, to_right, stop_ev, fs, ur_ev, nxt_left, acc, sbit;

   assign run = state != IDLE;

   i2s_bclk_gen #(.BCLK_DIV(BCLK_DIV)) u_bclk (
      .clk_12M  (clk_12M),
      .rst      (rst),
      .run      (run),
      .bclk     (bclk),
      .fall_tick(fall_tick),
      .rise_tick(rise_tick)
   );

   // fresh marks the LEFT state entered from IDLE: its first falling tick is a frame start
   // rather than a slot change. A stop is decided on the falling tick that would begin the
   // next LEFT slot; bclk then finishes its low half and parks high on the following rise.
   always_comb begin
      bound    = fall_tick && (fresh || bit_cnt == CW'(SLOT_W - 1));
      to_right = bound && !fresh && state == LEFT;
      stop_ev  = bound && state == RIGHT && !enable;
      fs       = bound && !to_right && !stop_ev;
      ur_ev    = fs && !hold_full;
      acc      = s_valid && s_ready;
      load_l   = hold_full ? hold_l : last_l;
      load_r   = hold_full ? hold_r : last_r;
      nxt_cnt  = bound ? '0 : bit_cnt + 1'b1;
      nxt_left = fs || (!to_right && state == LEFT);
      word     = fs ? load_l : nxt_left ? sh_l : sh_r;
      // sample left-aligned in the slot, then delayed one bit in I2S mode
      slot_vec = (SLOT_W'(word) << (SLOT_W - DATA_W)) >> MODE;
      sbit     = stop_ev ? 1'b0 : slot_vec[CW'(SLOT_W - 1) - nxt_cnt];
   end

   always_ff @(posedge clk_12M) begin
      if (rst) begin
         state       <= IDLE;
         bit_cnt     <= '0;
         fresh       <= 1'b0;
         stop_pend   <= 1'b0;
         hold_full   <= 1'b0;
         s_ready     <= 1'b1;
         hold_l      <= '0;
         hold_r      <= '0;
         last_l      <= '0;
         last_r      <= '0;
         sh_l        <= '0;
         sh_r        <= '0;
         lrclk       <= 1'b0;
         sdata       <= 1'b0;
         frame_start <= 1'b0;
         underrun    <= 1'b0;
      end else begin
         state       <= (state == IDLE && enable) ? LEFT : to_right ? RIGHT : fs ? LEFT :
                        (stop_pend && rise_tick) ? IDLE : state;
         fresh       <= state == IDLE ? enable : fresh && !bound;
         stop_pend   <= stop_ev || (stop_pend && !rise_tick);
         frame_start <= fs;
         underrun    <= ur_ev;
         hold_full   <= acc || (hold_full && !fs);
         s_ready     <= !(acc || (hold_full && !fs));
         hold_l      <= acc ? s_left : hold_l;
         hold_r      <= acc ? s_right : hold_r;
         sh_l        <= fs ? load_l : sh_l;
         sh_r        <= fs ? load_r : sh_r;
         last_l      <= fs ? load_l : last_l;
         last_r      <= fs ? load_r : last_r;
         bit_cnt     <= fall_tick ? nxt_cnt : bit_cnt;
         lrclk       <= fall_tick ? nxt_left : lrclk;
         sdata       <= fall_tick ? sbit : sdata;
      end
   end

`ifdef I2S_TX_STATS_EN
   always_ff @(posedge clk_12M) begin
      underrun_cnt <= (rst || stats_clr) ? '0 :
                      (ur_ev && underrun_cnt != 16'hFFFF) ? underrun_cnt + 16'd1 : underrun_cnt;
   end
`endif
endmodule

// File: tb/tb_i2s_tx_param.sv
// tb_i2s_tx_param: directed bench with a pair scoreboard for i2s_tx_param (I2S and LJ instances).
module tb_i2s_tx_param;
   import i2s_pkg::*;
   localparam int FRAME = frame_cycles(32, 2);
   typedef logic [47:0] pair_t;

   logic        clk = 1'b0, rst = 1'b1, enable = 1'b0, s_valid = 1'b0;
   logic [23:0] s_left = '0, s_right = '0;
   logic        s_ready, bclk, lrclk, sdata, frame_start, underrun;
   logic        lj_enable = 1'b0, lj_valid = 1'b0;
   logic [23:0] lj_left = '0, lj_right = '0;
   logic        lj_ready, lj_bclk, lj_lrclk, lj_sdata, lj_fs, lj_ur;
`ifdef I2S_TX_STATS_EN
   logic        stats_clr = 1'b0, lj_clr = 1'b0;
   logic [15:0] underrun_cnt, lj_cnt;
`endif
   int          tests = 0, fails = 0;

   pair_t       q[$];
   pair_t       cur = '0, pend = '0;
   bit          pend_v = 0, pb = 1, per_ok = 0;
   logic [63:0] fb = '0, lb = '0, lj_bits = '0, lj_lrs = '0;
   int          cnt = 100, cyc = 0, last_fs = 0, fs_seen = 0;

   always #5 clk = ~clk;

   i2s_tx_param #(.DATA_W(24), .SLOT_W(32), .BCLK_DIV(2), .MODE(MODE_I2S)) u_dut (
      .clk_12M(clk), .rst(rst), .enable(enable), .s_valid(s_valid), .s_ready(s_ready),
      .s_left(s_left), .s_right(s_right), .bclk(bclk), .lrclk(lrclk), .sdata(sdata),
      .frame_start(frame_start),
`ifdef I2S_TX_STATS_EN
      .stats_clr(stats_clr), .underrun_cnt(underrun_cnt),
`endif
      .underrun(underrun)
   );

   i2s_tx_param #(.DATA_W(24), .SLOT_W(32), .BCLK_DIV(2), .MODE(MODE_LJ)) u_lj (
      .clk_12M(clk), .rst(rst), .enable(lj_enable), .s_valid(lj_valid), .s_ready(lj_ready),
      .s_left(lj_left), .s_right(lj_right), .bclk(lj_bclk), .lrclk(lj_lrclk), .sdata(lj_sdata),
      .frame_start(lj_fs),
`ifdef I2S_TX_STATS_EN
      .stats_clr(lj_clr), .underrun_cnt(lj_cnt),
`endif
      .underrun(lj_ur)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Scoreboard: accepted pairs are queued one cycle late so that a pair taken on a
   // frame-start edge is not consumed by that same frame.
   always @(negedge clk) begin
      cyc++;
      if (rst) begin
         q.delete();
         cur = '0; pend_v = 0; cnt = 100; per_ok = 0; pb = 1;
      end else begin
         if (bclk && !pb && cnt < 100) begin
            fb = {fb[62:0], sdata};
            lb = {lb[62:0], lrclk};
            cnt++;
            if (cnt == 64) begin
               check("frame_data", fb, {1'b0, cur[47:24], 7'b0, 1'b0, cur[23:0], 7'b0});
               check("frame_lrclk", lb, {32'hFFFF_FFFF, 32'h0});
            end
         end
         if (frame_start) begin
            fs_seen++;
            check("underrun_at_fs", underrun, q.size() == 0);
            if (q.size() != 0) cur = q.pop_front();
            if (per_ok) check("frame_len", cyc - last_fs, FRAME);
            last_fs = cyc; per_ok = 1; cnt = 0; fb = '0; lb = '0;
         end else begin
            check("underrun_alone", underrun, 1'b0);
         end
         if (!enable) per_ok = 0;
         if (pend_v) q.push_back(pend);
         pend_v = s_valid && s_ready;
         pend = {s_left, s_right};
         pb = bclk;
      end
   end

   task automatic send(input logic [23:0] l, input logic [23:0] r);
      int n = 0;
      while (!s_ready && n < 2 * FRAME) begin @(posedge clk); #1; n++; end
      check("send_ready", s_ready, 1'b1);
      s_valid = 1'b1; s_left = l; s_right = r;
      @(posedge clk); #1;
      s_valid = 1'b0; s_left = ~l; s_right = ~r;
   endtask

   task automatic wait_fs(input int n);
      int got = 0;
      for (int i = 0; i < n * FRAME + 64 && got < n; i++) begin
         @(posedge clk); #1;
         if (frame_start) got++;
      end
      check("wait_fs", got, n);
   endtask

   initial begin
      logic [23:0] d;
      int          n_acc, n, f0;
      bit          acc_next, first, lpb;
      repeat (3) @(posedge clk);
      #1;
      check("reset_outs", {bclk, lrclk, sdata, frame_start, underrun, s_ready}, 6'b100001);
      rst = 1'b0;
      // basic frame, then two starved frames repeating it
      send(24'hA5A5A5, 24'h5A5A5A);
      check("ready_after_accept", s_ready, 1'b0);
      enable = 1'b1;
      wait_fs(3);
      // back-pressure with incrementing data
      d = 24'h000001; n_acc = 0; first = 1; s_valid = 1'b1;
      for (int i = 0; i < 4 * FRAME; i++) begin
         s_left = d; s_right = ~d;
         acc_next = s_ready;
         @(posedge clk); #1;
         if (acc_next) begin
            d++; n_acc++;
            if (first) begin check("bp_ready_drop", s_ready, 1'b0); first = 0; end
         end
      end
      s_valid = 1'b0;
      check("bp_accepts", n_acc >= 4 && n_acc <= 5, 1'b1);
      // graceful stop mid-LEFT
      wait_fs(1);
      repeat (40) @(posedge clk);
      #1;
      enable = 1'b0;
      f0 = fs_seen;
      repeat (2 * FRAME) @(posedge clk);
      #1;
      check("stop_no_fs", fs_seen - f0, 0);
      check("stop_idle", {bclk, lrclk, sdata}, 3'b100);
      // restart, then reset mid-RIGHT with a pair pending
      send(24'h123456, 24'hABCDEF);
      enable = 1'b1;
      wait_fs(1);
      send(24'h111111, 24'h222222);
      repeat (160) @(posedge clk);
      #1;
      rst = 1'b1; enable = 1'b0;
      @(posedge clk); #1;
      check("rst_mid_outs", {bclk, lrclk, sdata, frame_start, underrun, s_ready}, 6'b100001);
      @(posedge clk); #1;
      rst = 1'b0;
      // starved frames after reset repeat the cleared last sample
      enable = 1'b1;
      wait_fs(3);
`ifdef I2S_TX_STATS_EN
      check("stats_cnt3", underrun_cnt, 16'd3);
      stats_clr = 1'b1;
      @(posedge clk); #1;
      stats_clr = 1'b0;
      check("stats_clr", underrun_cnt, 16'd0);
`endif
      // left-justified instance
      lj_valid = 1'b1; lj_left = 24'h800001; lj_right = 24'h0F0F0F;
      @(posedge clk); #1;
      lj_valid = 1'b0; lj_left = '0; lj_right = '0;
      lj_enable = 1'b1;
      n = 0;
      while (!lj_fs && n < 100) begin @(posedge clk); #1; n++; end
      check("lj_fs_seen", lj_fs, 1'b1);
      check("lj_underrun", lj_ur, 1'b0);
      lpb = lj_bclk; n = 0;
      for (int i = 0; i < FRAME + 16 && n < 64; i++) begin
         @(posedge clk); #1;
         if (lj_bclk && !lpb) begin
            lj_bits = {lj_bits[62:0], lj_sdata};
            lj_lrs = {lj_lrs[62:0], lj_lrclk};
            n++;
         end
         lpb = lj_bclk;
      end
      check("lj_bits_seen", n, 64);
      check("lj_first_bit", lj_bits[63], 1'b1);
      check("lj_bit23", lj_bits[40], 1'b1);
      check("lj_frame", lj_bits, {24'h800001, 8'h0, 24'h0F0F0F, 8'h0});
      check("lj_lrclk", lj_lrs, {32'hFFFF_FFFF, 32'h0});
      enable = 1'b0; lj_enable = 1'b0;
      repeat (4) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
